// File: rtl/seq_left_shifter.sv
// rtl/seq_left_shifter.sv - four-stage sequential left shift/rotate of a 16-bit operand
// One binary-weighted stage per cycle (1, 2, 4, 8); result published only on completion.
module seq_left_shifter (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] data_in,
   input  logic [3:0]  shamt,
   input  logic        rotate,
   output logic        busy,
   output logic        done,
   output logic [15:0] data_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L4   = 3'd3,
      L8   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state;
   logic [15:0] work;
   logic [3:0]  amt;
   logic        rot;

   // Each stage either passes the word or shifts by its weight; rotate refills
   // the vacated LSBs with the bits that fall off the top.
   logic [15:0] s1, s2, s4, s8;

   always_comb begin
      s1 = amt[0] ? {work[14:0], rot ? work[15]    : 1'b0}  : work;
      s2 = amt[1] ? {work[13:0], rot ? work[15:14] : 2'b00} : work;
      s4 = amt[2] ? {work[11:0], rot ? work[15:12] : 4'h0}  : work;
      s8 = amt[3] ? {work[7:0],  rot ? work[15:8]  : 8'h00} : work;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         work     <= 16'h0000;
         amt      <= 4'h0;
         rot      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= 16'h0000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work  <= data_in;
                  amt   <= shamt;
                  rot   <= rotate;
                  busy  <= 1'b1;
                  state <= L1;
               end else begin
                  state <= IDLE;
               end
            end
            L1: begin
               work  <= s1;
               state <= L2;
            end
            L2: begin
               work  <= s2;
               state <= L4;
            end
            L4: begin
               work  <= s4;
               state <= L8;
            end
            L8: begin
               work     <= s8;
               data_out <= s8;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= DONE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_left_shifter.sv
// tb/tb_seq_left_shifter.sv - directed self-checking bench for seq_left_shifter
module tb_seq_left_shifter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] data_in;
   logic [3:0]  shamt;
   logic        rotate;
   logic        busy;
   logic        done;
   logic [15:0] data_out;

   int          n_checks;
   int          n_errors;
   logic [15:0] last_out;

   seq_left_shifter dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .data_in  (data_in),
      .shamt    (shamt),
      .rotate   (rotate),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one operation from IDLE, scramble the inputs after acceptance and
   // check the fixed 4-busy-cycle latency, held output and final result.
   task automatic do_op(input string tag, input logic [15:0] din, input logic [3:0] sh,
                        input logic r, input logic [15:0] exp);
      data_in = din; shamt = sh; rotate = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0; data_in = ~din; shamt = ~sh; rotate = ~r;
      for (int n = 1; n <= 4; n++) begin
         check({tag, " busy"}, {15'd0, busy}, 16'd1);
         if (n == 4) begin
            check({tag, " done_early"}, {15'd0, done}, 16'd0);
            check({tag, " held"}, data_out, last_out);
         end
         @(negedge clk);
      end
      check({tag, " done"}, {15'd0, done}, 16'd1);
      check({tag, " busy_off"}, {15'd0, busy}, 16'd0);
      check({tag, " result"}, data_out, exp);
      last_out = exp;
      @(negedge clk);
      check({tag, " done_pulse"}, {15'd0, done}, 16'd0);
   endtask

   initial begin
      int pulses;
      int gap;
      n_checks = 0; n_errors = 0; last_out = 16'h0000;
      reset = 1'b1; start = 1'b1; data_in = 16'hBEEF; shamt = 4'd3; rotate = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst busy", {15'd0, busy}, 16'd0);
      check("rst done", {15'd0, done}, 16'd0);
      check("rst data_out", data_out, 16'h0000);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);

      do_op("shl15",   16'h0001, 4'd15, 1'b0, 16'h8000);
      do_op("rol1",    16'h8001, 4'd1,  1'b1, 16'h0003);
      do_op("shl1",    16'h8001, 4'd1,  1'b0, 16'h0002);
      do_op("shl4",    16'h1234, 4'd4,  1'b0, 16'h2340);
      do_op("sh0",     16'h1234, 4'd0,  1'b0, 16'h1234);
      do_op("rol12",   16'h1234, 4'd12, 1'b1, 16'h4123);
      do_op("shl7",    16'hA5C3, 4'd7,  1'b0, 16'hE180);
      do_op("rol7",    16'hA5C3, 4'd7,  1'b1, 16'hE1D2);
      do_op("rolffff", 16'hFFFF, 4'd15, 1'b1, 16'hFFFF);

      // Start during L2 must be ignored.
      data_in = 16'h00FF; shamt = 4'd8; rotate = 1'b0; start = 1'b1;
      pulses = 0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; data_in = 16'hFFFF; shamt = 4'd0;
      pulses += int'(done);
      @(negedge clk);
      start = 1'b0;
      pulses += int'(done);
      check("ign held", data_out, last_out);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         pulses += int'(done);
         if (n == 1) check("ign result", data_out, 16'hFF00);
      end
      check("ign pulses", 16'(pulses), 16'd1);
      last_out = 16'hFF00;

      // Back-to-back with start held through the DONE cycle.
      data_in = 16'h0003; shamt = 4'd2; rotate = 1'b0; start = 1'b1;
      for (int n = 0; n < 5; n++) @(negedge clk);
      check("b2b done1", {15'd0, done}, 16'd1);
      check("b2b result1", data_out, 16'h000C);
      data_in = 16'h00F0; shamt = 4'd4; rotate = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b busy2", {15'd0, busy}, 16'd1);
      gap = 1;
      while (!done && gap < 12) begin
         @(negedge clk);
         gap++;
      end
      check("b2b gap", 16'(gap), 16'd5);
      check("b2b result2", data_out, 16'h0F00);
      last_out = 16'h0F00;
      @(negedge clk);

      // Reset during L4 aborts the operation.
      data_in = 16'hABCD; shamt = 4'd3; rotate = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort busy", {15'd0, busy}, 16'd0);
      check("abort done", {15'd0, done}, 16'd0);
      check("abort data_out", data_out, 16'h0000);
      reset = 1'b0;
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         pulses += int'(done);
      end
      check("abort no_done", 16'(pulses), 16'd0);
      last_out = 16'h0000;
      do_op("post_rst", 16'h0F0F, 4'd4, 1'b1, 16'hF0F0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
